arb_mux: RTL and testbench

Parametrised N-input arbitrated multiplexer with a registered output stage and valid/ready handshakes on every port. It generalises the static select-driven muxes to a self-selecting block: it picks one requesting source per cycle (round-robin or fixed priority), registers the winner's data, and reports which source won. It sits where several multi-cycle datapath sources share one sink, such as instruction fetch and load/store sharing the memory port, or multiple write-back sources feeding the register file.

---
 rtl/arb_mux.sv | 162 ++++++++++++++++
 tb/tb_arb_mux.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/arb_mux.sv
// arb_mux: N-input arbitrated multiplexer with a registered output stage.
// Picks one requesting source per cycle (round-robin or fixed priority),
// registers the winner's data and reports the winning index.
// Optional feature macro: ARB_MUX_LOCK_EN adds in_lock and a lock owner
// so that a source can keep the output for a multi-beat sequence.
module arb_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter bit RR    = 1'b1,
  localparam int SEL_W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
`ifdef ARB_MUX_LOCK_EN
  input  logic [N-1:0]         in_lock,
`endif
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_sel,
  input  logic                 out_ready
);

  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [SEL_W-1:0]   out_sel_q, out_sel_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;

  logic [N-1:0]       eligible;
  logic [N-1:0]       grant;
  logic               gnt_any;
  logic [SEL_W-1:0]   gnt_idx;
  logic [WIDTH-1:0]   win_data;
  logic               accept;
  logic               xfer;
  logic               ptr_adv;

  assign accept = !out_valid_q || out_ready;
  assign xfer   = accept && gnt_any && rst_n;

`ifdef ARB_MUX_LOCK_EN
  logic               locked_q, locked_d;
  logic [SEL_W-1:0]   owner_q, owner_d;
  logic [N-1:0]       owner_mask;
  logic               win_lock;

  // One-hot mask of the current lock owner
  always_comb begin
    owner_mask = '0;
    for (int i = 0; i < N; i++) begin
      owner_mask[i] = (owner_q == SEL_W'(i));
    end
  end

  // While locked only the owner competes, even when it is idle
  assign eligible = locked_q ? (in_valid & owner_mask) : in_valid;
  assign win_lock = |(grant & in_lock);
  // The pointer stays put across a locked sequence and moves on its last beat
  assign ptr_adv  = xfer && !win_lock;

  // Lock next state: a locking beat claims ownership, an unlocking beat releases it
  always_comb begin
    locked_d = locked_q;
    owner_d  = owner_q;
    if (xfer) begin
      if (win_lock) begin
        locked_d = 1'b1;
        owner_d  = gnt_idx;
      end else begin
        locked_d = 1'b0;
      end
    end
  end

  // Lock state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_q <= 1'b0;
      owner_q  <= '0;
    end else begin
      locked_q <= locked_d;
      owner_q  <= owner_d;
    end
  end
`else
  assign eligible = in_valid;
  assign ptr_adv  = xfer;
`endif

  // Grant search: lowest eligible index at or above ptr, else lowest overall.
  // With RR=0 the pointer is pinned at 0, which gives plain fixed priority.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        gnt_any = 1'b1;
        gnt_idx = SEL_W'(i);
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (eligible[i] && (SEL_W'(i) >= ptr_q)) begin
        gnt_idx = SEL_W'(i);
      end
    end
  end

  // One-hot grant and winning data, selected without variable part-selects
  always_comb begin
    grant    = '0;
    win_data = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = gnt_any && (gnt_idx == SEL_W'(i));
      if (grant[i]) begin
        win_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Ready is pass-through from the sink; nothing is offered while in reset
  assign in_ready = (accept && rst_n) ? grant : '0;

  // Output stage next state: load on transfer, drain when idle, hold on stall
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (accept) begin
      out_valid_d = gnt_any;
      if (gnt_any) begin
        out_data_d = win_data;
        out_sel_d  = gnt_idx;
      end
    end
    if (RR && ptr_adv) begin
      ptr_d = (gnt_idx == SEL_W'(N - 1)) ? '0 : gnt_idx + SEL_W'(1);
    end
  end

  // Output and pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: a round-robin instance and a fixed-priority
// instance share clock and reset. Lock steps are built with ARB_MUX_LOCK_EN.
module tb_arb_mux;

  localparam int W = 32;
  localparam int N = 4;
  localparam logic [N*W-1:0] DATA = {32'h44444444, 32'h33333333,
                                     32'h22222222, 32'h11111111};

  logic           clk = 1'b0;
  logic           rst_n;

  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_lock;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_ready;

  logic [N-1:0]   fp_valid;
  logic [N*W-1:0] fp_data;
  logic [N-1:0]   fp_lock;
  logic [N-1:0]   fp_in_ready;
  logic           fp_out_valid;
  logic [W-1:0]   fp_out_data;
  logic [1:0]     fp_out_sel;
  logic           fp_out_ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  arb_mux #(.WIDTH(W), .N(N), .RR(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef ARB_MUX_LOCK_EN
    .in_lock   (in_lock),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  arb_mux #(.WIDTH(W), .N(N), .RR(1'b0)) dut_fp (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (fp_valid),
    .in_data   (fp_data),
`ifdef ARB_MUX_LOCK_EN
    .in_lock   (fp_lock),
`endif
    .in_ready  (fp_in_ready),
    .out_valid (fp_out_valid),
    .out_data  (fp_out_data),
    .out_sel   (fp_out_sel),
    .out_ready (fp_out_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] src_data(input int i);
    return 32'h11111111 * (i + 1);
  endfunction

  initial begin
    rst_n        = 1'b1;
    in_valid     = 4'b1111;
    in_data      = DATA;
    in_lock      = 4'b0000;
    out_ready    = 1'b1;
    fp_valid     = 4'b1010;
    fp_data      = DATA;
    fp_lock      = 4'b0000;
    fp_out_ready = 1'b1;
    #2 rst_n = 1'b0;

    // Reset with every input requesting
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_sel", 32'(out_sel), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_fp_in_ready", 32'(fp_in_ready), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("first_grant", 32'(in_ready), 32'b0001);
    check("fp_first_grant", 32'(fp_in_ready), 32'b0010);

    // Round-robin across all four sources at full throughput
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      check("rr_valid", 32'(out_valid), 32'd1);
      check("rr_sel", 32'(out_sel), 32'(k % 4));
      check("rr_data", out_data, src_data(k % 4));
      check("rr_in_ready", 32'(in_ready), 32'(4'b0001 << ((k + 1) % 4)));
      check("fp_sel", 32'(fp_out_sel), 32'd1);
      check("fp_in_ready", 32'(fp_in_ready), 32'b0010);
    end

    // Fixed priority: source 3 only wins once source 1 drops
    fp_valid = 4'b1000;
    #1;
    check("fp_drop_ready", 32'(fp_in_ready), 32'b1000);
    @(posedge clk);
    #1;
    check("fp_sel3", 32'(fp_out_sel), 32'd3);
    check("fp_data3", fp_out_data, 32'h44444444);
    check("rr_sel_after", 32'(out_sel), 32'd2);
    fp_valid = 4'b0000;

    // Backpressure: beat from source 2 holds for three cycles
    out_ready = 1'b0;
    #1;
    check("bp_ready0", 32'(in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("bp_sel", 32'(out_sel), 32'd2);
      check("bp_data", out_data, 32'h33333333);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end

    // Release with ptr=3 and only sources 0 and 2 valid: scan wraps to 0
    out_ready = 1'b1;
    in_valid  = 4'b0101;
    #1;
    check("wrap_ready", 32'(in_ready), 32'b0001);
    @(posedge clk);
    #1;
    check("wrap_sel", 32'(out_sel), 32'd0);
    check("wrap_data", out_data, 32'h11111111);
    in_valid = 4'b1111;
    #1;
    check("ptr_after_wrap", 32'(in_ready), 32'b0010);

    // No requests: output drains, data and sel hold
    in_valid = 4'b0000;
    #1;
    check("idle_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_sel_hold", 32'(out_sel), 32'd0);
    check("idle_data_hold", out_data, 32'h11111111);

`ifdef ARB_MUX_LOCK_EN
    // Source 2 sends three beats with lock 1,1,0 while source 0 waits
    in_valid = 4'b0101;
    in_lock  = 4'b0100;
    #1;
    check("lk_ready_first", 32'(in_ready), 32'b0100);
    @(posedge clk);
    #1;
    check("lk_sel1", 32'(out_sel), 32'd2);
    in_valid = 4'b0001;
    #1;
    check("lk_owner_idle", 32'(in_ready), 32'd0);
    in_valid = 4'b0101;
    #1;
    check("lk_owner_ready", 32'(in_ready), 32'b0100);
    @(posedge clk);
    #1;
    check("lk_sel2", 32'(out_sel), 32'd2);
    in_lock = 4'b0000;
    @(posedge clk);
    #1;
    check("lk_sel3", 32'(out_sel), 32'd2);
    check("lk_unlocked_ready", 32'(in_ready), 32'b0001);
    @(posedge clk);
    #1;
    check("lk_then0", 32'(out_sel), 32'd0);
    check("lk_then0_data", out_data, 32'h11111111);

    // Reset while locked clears the lock
    in_lock = 4'b0100;
    @(posedge clk);
    #1;
    check("lk2_sel", 32'(out_sel), 32'd2);
    rst_n = 1'b0;
    #1;
    check("lk2_rst_valid", 32'(out_valid), 32'd0);
    check("lk2_rst_sel", 32'(out_sel), 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    in_lock = 4'b0000;
    #1;
    check("lk2_post_rst_ready", 32'(in_ready), 32'b0001);
    @(posedge clk);
    #1;
    check("lk2_post_rst_sel", 32'(out_sel), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
